mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-store bus (MemWrite / DataAdr / WriteData); the peripheral end of the store interface. Stores to its data register enqueue bytes into a small FIFO, which a bit-timer FSM serializes as 8N1 frames on `tx`. A status register is returned combinationally on `ReadData` for loads, so firmware can poll before storing.

## Interface
- BASE_ADDR, 32'h0000_0200: byte address of TXDATA; STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values 2..65535.
- FIFO_DEPTH, 4: byte entries; power of two, 2..16.

- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- MemWrite  in  1  store strobe from core; valid in the cycle it is high.
- DataAdr  in  32  byte address of the current access.
- WriteData  in  32  store data.
- ReadData  out  32  combinational: STATUS when DataAdr==BASE_ADDR+4, else 32'h0.
- tx  out  1  serial line, idle high.

## Operation
- Address match is exact 32-bit compare; other addresses are ignored.
- TXDATA write (MemWrite & DataAdr==BASE_ADDR): WriteData[7:0] pushed if FIFO not full; WriteData[31:8] ignored. If full, byte dropped, `ovf` set.
- STATUS write (MemWrite & DataAdr==BASE_ADDR+4): WriteData[3]==1 clears `ovf`; other bits ignored. Set takes priority over clear in the same cycle (cannot coincide, but priority is fixed).
- STATUS layout: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] ovf, [8:4] FIFO count (0..FIFO_DEPTH), others 0.
- Full is evaluated on pre-edge state: a push while full is dropped even if a pop occurs on the same edge. Push and pop on the same edge with FIFO non-full and non-empty leaves count unchanged.
- FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: tx=1. If FIFO non-empty: pop head into shift register, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; each CLKS_PER_BIT cycles shift right and increment index; after bit 7 go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At final cycle: FIFO non-empty -> pop, go START directly (no idle gap); else IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, reloads to 0 on every state/bit change; width ceil(log2(CLKS_PER_BIT)), minimum 1.
- FIFO pointers wrap modulo FIFO_DEPTH; count kept separately, width log2(FIFO_DEPTH)+1.

## Timing
- Reset values: tx=1, FSM=IDLE, FIFO empty (count 0, pointers 0), ovf=0, timer 0, shift register 0. ReadData after reset with DataAdr==BASE_ADDR+4: 32'h0000_0002.
- Reset mid-frame: tx is 1 from the next edge; queued bytes discarded; reset wins over a simultaneous store.
- Push latency: byte stored at the edge where the store is sampled; count visible on STATUS from the following cycle.
- Start latency from empty/idle: push at edge N, pop at edge N+1, tx low after edge N+1 (one-cycle IDLE dwell).
- Frame duration: exactly 10*CLKS_PER_BIT cycles from START entry to end of STOP; back-to-back frames are contiguous.
- busy is 1 from START entry until return to IDLE.
- ReadData has no register stage; it follows DataAdr within the cycle, independent of MemWrite.

## Test plan
- Reset: assert reset 2 cycles with MemWrite=1 to TXDATA -> tx=1, STATUS=32'h2, no frame emitted.
- Single byte, CLKS_PER_BIT=4: store 32'hFFFF_FF55 to BASE_ADDR -> tx samples at 4-cycle pitch read 0,1,0,1,0,1,0,1,0,1; frame 40 cycles; STATUS returns to 32'h2.
- Back-to-back: store 8'hA5 then 8'h0F on consecutive cycles -> two contiguous 40-cycle frames, no idle cycle between them, then IDLE.
- Overflow, FIFO_DEPTH=4: 6 consecutive stores 8'h01..8'h06 -> bytes 01..05 transmitted (first popped immediately, four queued), 06 dropped, STATUS[3]=1; store 32'h8 to BASE_ADDR+4 -> STATUS[3]=0.
- Reset mid-frame during DATA bit 3 with 2 bytes queued -> tx=1 next cycle, count 0, no further frames.
- Address decode: stores to BASE_ADDR+1, BASE_ADDR+8, 32'h0 -> count stays 0; loads at BASE_ADDR and BASE_ADDR+8 -> ReadData=0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: processor data-store bus between the core (master) and the UART peripheral (slave)
//   MemWrite  : store strobe, valid in the cycle it is high
//   DataAdr   : byte address of the access
//   WriteData : store data
//   ReadData  : combinational load data returned by the peripheral
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    modport master (output MemWrite, DataAdr, WriteData, input ReadData);
    modport slave (input MemWrite, DataAdr, WriteData, output ReadData);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : store bus slave; TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4
//   tx    : serial line, idle high
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, next_state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [TW-1:0] timer;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic ovf, full, empty, busy, tick, wr_data, wr_stat, push, pop;
    logic unused_wdata;
    assign wr_data = bus.MemWrite && bus.DataAdr == BASE_ADDR;
    assign wr_stat = bus.MemWrite && bus.DataAdr == BASE_ADDR + 32'd4;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign busy = state != IDLE;
    assign tick = timer == LAST_TICK;
    // full is the pre-edge value, so a store while full is dropped even if a pop happens on the same edge
    assign push = wr_data && !full;
    assign unused_wdata = ^bus.WriteData[31:8];
    assign bus.ReadData = bus.DataAdr == BASE_ADDR + 32'd4 ? {28'(count), ovf, busy, empty, full} : 32'h0;
    assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    always_comb begin
        next_state = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                next_state = empty ? IDLE : START;
            end
            START: next_state = tick ? DATA : START;
            DATA: next_state = tick && bit_idx == 3'd7 ? STOP : DATA;
            STOP: begin
                // a queued byte goes straight to START so frames stay contiguous
                pop = tick && !empty;
                next_state = !tick ? STOP : empty ? IDLE : START;
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            bit_idx <= '0;
            shift <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ovf <= 1'b0;
        end else begin
            state <= next_state;
            timer <= (state == IDLE || tick) ? '0 : timer + 1'b1;
            if (pop) begin
                shift <= mem[rd_ptr];
                bit_idx <= '0;
                rd_ptr <= rd_ptr + 1'b1;
            end else if (state == DATA && tick) begin
                shift <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
            if (wr_data && full) ovf <= 1'b1;
            else if (wr_stat && bus.WriteData[3]) ovf <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.WriteData[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx with a frame-decoding scoreboard
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam logic [31:0] STAT = BASE + 32'd4;
    localparam int CPB = 4;
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd_adr;
        logic [31:0] exp_rd;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    logic tx;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int frames = 0;
    int starts[$];
    logic [7:0] expq[$];
    vec_t vecs[7];
    mmio_uart_tx_if bus();
    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .tx(tx)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit exp);
        bus.MemWrite = 1'b1;
        bus.DataAdr = a;
        bus.WriteData = d;
        if (exp) expq.push_back(d[7:0]);
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        bus.DataAdr = STAT;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            bus.DataAdr = STAT;
            #1;
            done = bus.ReadData == 32'h2;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, status %h expected 00000002", name, bus.ReadData);
        end
    endtask

    // frame decoder: checks every cycle of each frame against the byte popped from the scoreboard
    initial begin : monitor
        logic [7:0] eb;
        logic exp_b;
        int bad;
        bit ab;
        bit have;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                starts.push_back(cyc);
                frames++;
                have = expq.size() > 0;
                eb = have ? expq.pop_front() : 8'h00;
                bad = 0;
                ab = 1'b0;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset) begin
                        ab = 1'b1;
                        break;
                    end
                    if (c < CPB) exp_b = 1'b0;
                    else if (c < 9 * CPB) exp_b = eb[c / CPB - 1];
                    else exp_b = 1'b1;
                    if (tx !== exp_b) bad++;
                end
                if (!ab) begin
                    checks++;
                    if (!have || bad != 0) begin
                        errors++;
                        $display("FAIL frame: byte %h expected=%0d, %0d bad bit cycles, required 0", eb, have, bad);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : test
        int f0;
        bit seen;
        vecs[0] = '{1'b1, BASE + 32'd1, 32'h11, STAT, 32'h2};
        vecs[1] = '{1'b1, BASE + 32'd8, 32'h22, STAT, 32'h2};
        vecs[2] = '{1'b1, 32'h0, 32'h33, STAT, 32'h2};
        vecs[3] = '{1'b0, BASE, 32'h0, BASE, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 32'h0, BASE + 32'd8, 32'h0};
        vecs[5] = '{1'b1, STAT, 32'h8, STAT, 32'h2};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b1;
        bus.MemWrite = 1'b1;
        bus.DataAdr = BASE;
        bus.WriteData = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        bus.DataAdr = STAT;
        #1;
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_status", bus.ReadData, 32'h2);
        repeat (50) @(posedge clk);
        #1;
        chk("reset_no_frame", frames, 0);

        foreach (vecs[i]) begin
            bus.MemWrite = vecs[i].we;
            bus.DataAdr = vecs[i].adr;
            bus.WriteData = vecs[i].wd;
            @(posedge clk);
            #1;
            bus.MemWrite = 1'b0;
            bus.DataAdr = vecs[i].rd_adr;
            #1;
            chk($sformatf("vec%0d", i), bus.ReadData, vecs[i].exp_rd);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("decode_no_frame", frames, 0);

        starts.delete();
        store(BASE, 32'hFFFF_FF55, 1'b1);
        f0 = cyc;
        #1;
        chk("push_count", bus.ReadData, 32'h10);
        @(posedge clk);
        #2;
        chk("busy_status", bus.ReadData, 32'h6);
        wait_idle("single_idle", 100);
        chk("single_frames", frames, 1);
        chk("start_latency", starts.size() > 0 ? starts[0] - f0 : -1, 1);

        starts.delete();
        store(BASE, 32'hA5, 1'b1);
        store(BASE, 32'h0F, 1'b1);
        wait_idle("b2b_idle", 200);
        chk("b2b_frames", frames, 3);
        chk("b2b_gap", starts.size() > 1 ? starts[1] - starts[0] : -1, 10 * CPB);

        for (int i = 1; i <= 6; i++) store(BASE, i, i <= 5);
        #1;
        chk("ovf_status", bus.ReadData, 32'h4D);
        store(STAT, 32'h8, 1'b0);
        #1;
        chk("ovf_clear", bus.ReadData, 32'h45);
        wait_idle("ovf_idle", 400);
        chk("ovf_frames", frames, 8);

        starts.delete();
        store(BASE, 32'h3C, 1'b1);
        store(BASE, 32'h5A, 1'b0);
        store(BASE, 32'h99, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = starts.size() > 0;
        end
        chk("midreset_started", {31'h0, seen}, 32'h1);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.DataAdr = STAT;
        #1;
        chk("midreset_tx", {31'h0, tx}, 32'h1);
        chk("midreset_status", bus.ReadData, 32'h2);
        repeat (100) @(posedge clk);
        #1;
        chk("midreset_no_frame", frames, 9);
        chk("scoreboard_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
